req_encoder8: RTL and testbench
===============================

// Module: req_encoder8
// PURPOSE
//   Sequential 8-to-3 priority encoder; inverse of the 3-to-8 decoder.
//   - Latches rising edges on 8 request lines into a sticky pending vector.
//   - Presents the winning request index with a valid/ack handshake.
//   - Clears each served bit on ack.
//   - Feeds decoder-side select logic, which turns the index back into one-hot.
// PARAMETERS
//   LOW_WINS  0  0: highest set index wins (bit7 top priority); 1: lowest set index wins
// PORTS
//   clk         in   1  system clock, rising edge
//   rst_n       in   1  asynchronous active-low reset
//   req_i       in   8  request lines; a 0->1 transition posts a request
//   clr_i       in   1  synchronous clear of all pending requests
//   ack_i       in   1  consumer accepts idx_o (only meaningful while valid_o=1)
//   idx_o       out  3  encoded index of the presented request
//   valid_o     out  1  idx_o is valid and held stable until acked
//   pending_o   out  8  current sticky pending vector (registered)
//   overflow_o  out  1  one-cycle pulse: a rise hit an already-pending bit
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-low.
//   Reset values: req_q=0, pending=0, idx_o=0, valid_o=0, overflow_o=0, state=IDLE.
//   Edge detect:
//     - req_q <= req_i every cycle.
//     - rise = req_i & ~req_q (combinational).
//     - A level held high posts exactly one request.
//   Served one-hot:
//     - served = valid_o & ack_i ? onehot(idx_o) : 0.
//   Pending update:
//     - next_pend = (pending & ~served) | rise.
//     - rise wins over served on the same bit, so the bit stays pending.
//   Overflow:
//     - overflow_o <= |(rise & pending & ~served).
//     - Registered, so it pulses the cycle after the offending rise.
//   Selection:
//     - win = priority-encode(next_pend) per LOW_WINS.
//     - Purely a function of next_pend.
//   FSM IDLE:
//     - If next_pend != 0: idx_o <= win, valid_o <= 1, go PRESENT.
//   FSM PRESENT:
//     - idx_o and valid_o hold while ack_i=0, even if a higher-priority request
//       arrives (no preemption).
//     - On ack_i=1 with next_pend != 0: idx_o <= win, stay PRESENT (back-to-back, no bubble).
//     - On ack_i=1 with next_pend == 0: valid_o <= 0, go IDLE.
//   Clear:
//     - clr_i=1 overrides everything else: pending <= 0, valid_o <= 0,
//       overflow_o <= 0, state <= IDLE.
//     - Rises in the same cycle are discarded; req_q still updates.
//   Latency:
//     - Rise sampled at edge k: pending_o set after edge k.
//     - valid_o asserted after edge k if IDLE.
//   Ack while valid_o=0 is ignored. idx_o keeps its last value when valid_o=0.
//   Async reset mid-handshake: all state returns to reset values immediately.
//   No requests are retained.
// TESTING
//   T1 Single request:
//     - req_i 0x00->0x10 at edge 1, ack_i=1 at edge 3.
//     - pending_o=0x10 and valid_o=1, idx_o=4 after edge 1.
//     - valid_o=0, pending_o=0 after edge 3.
//   T2 Priority:
//     - req_i 0x00->0x85 in one cycle, ack_i held 1.
//     - idx_o sequence 7,2,0 on consecutive cycles, then valid_o=0.
//     - With LOW_WINS=1: sequence 0,2,7.
//   T3 No preemption:
//     - Present idx=1 with ack_i=0, then raise req_i bit6.
//     - idx_o stays 1 until acked; next presented idx_o=6.
//   T4 Overflow and collision:
//     - Re-raise bit3 while bit3 is pending and not acked: overflow_o=1 for one cycle.
//     - Raise bit3 in the same cycle it is acked: no overflow, idx_o=3 re-presented.
//   T5 Clear vs reset:
//     - clr_i=1 with pending=0xFF and a new rise: pending_o=0, valid_o=0 next cycle.
//     - Drop rst_n mid-PRESENT: all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/req_encoder8.sv
// Sequential 8-to-3 priority encoder: sticky rising-edge request capture with a valid/ack
// presentation of the winning index. Latency: one edge from rise to pending/valid. Ack pops in place.
module req_encoder8 #(
    parameter bit LOW_WINS = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_i,
    input  logic       clr_i,
    input  logic       ack_i,
    output logic [2:0] idx_o,
    output logic       valid_o,
    output logic [7:0] pending_o,
    output logic       overflow_o
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t     state_q, state_d;
    logic [7:0] req_q;
    logic [7:0] pend_q, pend_d;
    logic [2:0] idx_q, idx_d;
    logic       valid_q, valid_d;
    logic       ovf_q, ovf_d;

    logic [7:0] rise;
    logic [7:0] served;
    logic [7:0] next_pend;
    logic [2:0] win;

    assign rise = req_i & ~req_q;

    always_comb begin
        served = '0;
        if (valid_q && ack_i) begin
            served[idx_q] = 1'b1;
        end
    end

    // A fresh rise on a bit being served keeps that bit pending.
    assign next_pend = (pend_q & ~served) | rise;

    // Last hit in scan order wins, so the scan direction sets the priority.
    always_comb begin
        win = 3'd0;
        if (LOW_WINS) begin
            for (int i = 7; i >= 0; i--) begin
                if (next_pend[i]) win = 3'(i);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (next_pend[i]) win = 3'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = next_pend;
        idx_d   = idx_q;
        valid_d = valid_q;
        ovf_d   = |(rise & pend_q & ~served);
        if (clr_i) begin
            pend_d  = '0;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (next_pend != 8'd0) begin
                        idx_d   = win;
                        valid_d = 1'b1;
                        state_d = PRESENT;
                    end
                end
                PRESENT: begin
                    if (ack_i) begin
                        if (next_pend != 8'd0) begin
                            idx_d = win;
                        end else begin
                            valid_d = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            pend_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_i;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign idx_o      = idx_q;
    assign valid_o    = valid_q;
    assign pending_o  = pend_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_req_encoder8.sv
// Bench for req_encoder8: both priority orders side by side, directed scenarios plus
// randomized traffic against a bit-array reference model.
module tb_req_encoder8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req_i = '0;
    logic       clr_i = 1'b0;
    logic       ack_i = 1'b0;

    logic [2:0] idx_h, idx_l;
    logic       valid_h, valid_l;
    logic [7:0] pend_h, pend_l;
    logic       ovf_h, ovf_l;

    int checks = 0;
    int errors = 0;

    // Reference state: index 0 = highest wins, index 1 = lowest wins.
    bit m_reqq [8];
    bit m_pend [2][8];
    int m_idx  [2];
    bit m_valid[2];
    bit m_ovf  [2];

    always #5 clk = ~clk;

    req_encoder8 #(.LOW_WINS(1'b0)) dut_h (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .clr_i(clr_i), .ack_i(ack_i),
        .idx_o(idx_h), .valid_o(valid_h), .pending_o(pend_h), .overflow_o(ovf_h)
    );

    req_encoder8 #(.LOW_WINS(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .clr_i(clr_i), .ack_i(ack_i),
        .idx_o(idx_l), .valid_o(valid_l), .pending_o(pend_l), .overflow_o(ovf_l)
    );

    task automatic model_reset();
        for (int b = 0; b < 8; b++) m_reqq[b] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int b = 0; b < 8; b++) m_pend[k][b] = 1'b0;
            m_idx[k] = 0; m_valid[k] = 1'b0; m_ovf[k] = 1'b0;
        end
    endtask

    // One clock edge of the request/serve rules, applied to current inputs.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int srv;
            int win;
            bit np[8];
            bit any;
            bit ov;
            bit rise;
            bit keep;
            srv = (m_valid[k] && ack_i) ? m_idx[k] : -1;
            any = 1'b0; ov = 1'b0; win = -1;
            for (int b = 0; b < 8; b++) begin
                rise  = req_i[b] && !m_reqq[b];
                keep  = m_pend[k][b] && (b != srv);
                np[b] = keep || rise;
                ov    = ov || (rise && keep);
                any   = any || np[b];
            end
            for (int s = 0; s < 8; s++) begin
                int b;
                b = (k == 1) ? s : 7 - s;
                if (np[b] && win < 0) win = b;
            end
            if (clr_i) begin
                for (int b = 0; b < 8; b++) m_pend[k][b] = 1'b0;
                m_valid[k] = 1'b0;
                m_ovf[k]   = 1'b0;
            end else begin
                for (int b = 0; b < 8; b++) m_pend[k][b] = np[b];
                m_ovf[k] = ov;
                if (!m_valid[k]) begin
                    if (any) begin m_valid[k] = 1'b1; m_idx[k] = win; end
                end else if (ack_i) begin
                    if (any) m_idx[k] = win;
                    else     m_valid[k] = 1'b0;
                end
            end
        end
        for (int b = 0; b < 8; b++) m_reqq[b] = req_i[b];
    endtask

    function automatic logic [7:0] m_pvec(int k);
        logic [7:0] v;
        for (int b = 0; b < 8; b++) v[b] = m_pend[k][b];
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_i = '0; clr_i = 1'b0; ack_i = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({valid_h, idx_h, pend_h, ovf_h, valid_l, idx_l, pend_l, ovf_l} !== 26'd0) begin
            errors++;
            $display("FAIL reset: got h v=%0b i=%0d p=%02h o=%0b l v=%0b i=%0d p=%02h o=%0b, required all 0",
                     valid_h, idx_h, pend_h, ovf_h, valid_l, idx_l, pend_l, ovf_l);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        req_i = 8'h10;
        step();
        checks++;
        if ({valid_h, idx_h, pend_h} !== {1'b1, 3'd4, 8'h10} || idx_l !== 3'd4) begin
            errors++;
            $display("FAIL single_present: got v=%0b i=%0d p=%02h il=%0d, required v=1 i=4 p=10 il=4",
                     valid_h, idx_h, pend_h, idx_l);
        end
        step();
        ack_i = 1'b1;
        step();
        checks++;
        if ({valid_h, pend_h, valid_l, pend_l} !== 18'd0) begin
            errors++;
            $display("FAIL single_ack: got v=%0b p=%02h vl=%0b pl=%02h, required all 0",
                     valid_h, pend_h, valid_l, pend_l);
        end
        ack_i = 1'b0;
    endtask

    task automatic test_priority();
        int exp_h[3] = '{7, 2, 0};
        int exp_l[3] = '{0, 2, 7};
        do_reset();
        req_i = 8'h85; ack_i = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (!valid_h || !valid_l || int'(idx_h) != exp_h[i] || int'(idx_l) != exp_l[i]) begin
                errors++;
                $display("FAIL priority[%0d]: got vh=%0b ih=%0d vl=%0b il=%0d, required ih=%0d il=%0d valid",
                         i, valid_h, idx_h, valid_l, idx_l, exp_h[i], exp_l[i]);
            end
            step();
        end
        checks++;
        if (valid_h !== 1'b0 || valid_l !== 1'b0) begin
            errors++;
            $display("FAIL priority_drain: got vh=%0b vl=%0b, required 0 0", valid_h, valid_l);
        end
        ack_i = 1'b0; req_i = '0;
    endtask

    task automatic test_no_preempt();
        do_reset();
        req_i = 8'h02;
        step();
        req_i = 8'h42;
        repeat (3) step();
        checks++;
        if ({valid_h, idx_h, pend_h} !== {1'b1, 3'd1, 8'h42}) begin
            errors++;
            $display("FAIL hold_idx: got v=%0b i=%0d p=%02h, required v=1 i=1 p=42", valid_h, idx_h, pend_h);
        end
        ack_i = 1'b1;
        step();
        checks++;
        if ({valid_h, idx_h, valid_l, idx_l} !== {1'b1, 3'd6, 1'b1, 3'd6}) begin
            errors++;
            $display("FAIL next_after_ack: got ih=%0d il=%0d vh=%0b vl=%0b, required 6 6 1 1",
                     idx_h, idx_l, valid_h, valid_l);
        end
        step();
        checks++;
        if (valid_h !== 1'b0 || idx_h !== 3'd6) begin
            errors++;
            $display("FAIL idle_keeps_idx: got v=%0b i=%0d, required v=0 i=6", valid_h, idx_h);
        end
        ack_i = 1'b0; req_i = '0;
    endtask

    task automatic test_overflow();
        do_reset();
        req_i = 8'h08; step();
        req_i = 8'h00; step();
        req_i = 8'h08; step();
        checks++;
        if (ovf_h !== 1'b1 || ovf_l !== 1'b1 || idx_h !== 3'd3) begin
            errors++;
            $display("FAIL overflow_pulse: got oh=%0b ol=%0b i=%0d, required 1 1 3", ovf_h, ovf_l, idx_h);
        end
        step();
        checks++;
        if (ovf_h !== 1'b0) begin
            errors++;
            $display("FAIL overflow_one_cycle: got %0b, required 0", ovf_h);
        end
        req_i = 8'h00; step();
        req_i = 8'h08; ack_i = 1'b1; step();
        checks++;
        if ({ovf_h, valid_h, idx_h, pend_h} !== {1'b0, 1'b1, 3'd3, 8'h08}) begin
            errors++;
            $display("FAIL collision: got o=%0b v=%0b i=%0d p=%02h, required o=0 v=1 i=3 p=08",
                     ovf_h, valid_h, idx_h, pend_h);
        end
        req_i = 8'h00; step();
        ack_i = 1'b0;
    endtask

    task automatic test_clear_reset();
        do_reset();
        req_i = 8'hFF; step();
        checks++;
        if (pend_h !== 8'hFF) begin
            errors++;
            $display("FAIL fill: got p=%02h, required FF", pend_h);
        end
        req_i = 8'h00; step();
        req_i = 8'h01; clr_i = 1'b1; step();
        checks++;
        if ({pend_h, valid_h, ovf_h, pend_l, valid_l, ovf_l} !== 20'd0) begin
            errors++;
            $display("FAIL clear: got p=%02h v=%0b o=%0b pl=%02h vl=%0b ol=%0b, required all 0",
                     pend_h, valid_h, ovf_h, pend_l, valid_l, ovf_l);
        end
        clr_i = 1'b0; step();
        checks++;
        if (pend_h !== 8'h00 || valid_h !== 1'b0) begin
            errors++;
            $display("FAIL clear_discards_rise: got p=%02h v=%0b, required 00 0", pend_h, valid_h);
        end
        req_i = 8'h04; step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({valid_h, idx_h, pend_h, ovf_h, valid_l, idx_l, pend_l, ovf_l} !== 26'd0) begin
            errors++;
            $display("FAIL async_reset: got vh=%0b ih=%0d ph=%02h vl=%0b il=%0d pl=%02h, required all 0",
                     valid_h, idx_h, pend_h, valid_l, idx_l, pend_l);
        end
        req_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            req_i = 8'($urandom) & 8'($urandom);
            ack_i = 1'($urandom_range(0, 1));
            clr_i = ($urandom_range(0, 40) == 0);
            step();
            for (int k = 0; k < 2; k++) begin
                logic [12:0] got;
                logic [12:0] exp;
                got = (k == 0) ? {valid_h, idx_h, pend_h, ovf_h} : {valid_l, idx_l, pend_l, ovf_l};
                exp = {m_valid[k], 3'(m_idx[k]), m_pvec(k), m_ovf[k]};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL random[%0d] low_wins=%0d: got v/i/p/o=%0b/%0d/%02h/%0b, required %0b/%0d/%02h/%0b",
                             n, k, got[12], got[11:9], got[8:1], got[0], exp[12], exp[11:9], exp[8:1], exp[0]);
                end
            end
        end
        req_i = '0; ack_i = 1'b0; clr_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_no_preempt();
        test_overflow();
        test_clear_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
